bd_tx_modulator: RTL and testbench

- Transmit-side counterpart of the BD receive chain.
- Accepts a two-byte payload (BYTE_0, then BYTE_1) from the host over a valid/ready byte interface.
- Manchester-encodes the payload, prefixes a raw sync word, and drives the chips as 8-bit DAC amplitude samples.
- Raises a one-cycle host interrupt when the frame has been sent.

---
 rtl/bd_tx_pkg.sv | 25 ++
 rtl/bd_tx_chip_shifter.sv | 61 ++++++
 rtl/bd_tx_modulator.sv | 155 +++++++++++++++
 tb/tb_bd_tx_modulator.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/bd_tx_pkg.sv
// bd_tx_pkg: shared types, frame constants and the Manchester helper
// for the BD transmit modulator. The optional parity feature is
// controlled by the BD_TX_PARITY_EN macro in bd_tx_modulator.
package bd_tx_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_B1 = 3'd1,
    SYNC    = 3'd2,
    DATA    = 3'd3,
    PARITY  = 3'd4,
    DONE    = 3'd5
  } bd_tx_state_t;

  // Chips per frame segment (sync is raw, data is Manchester over 16 bits)
  localparam int SYNC_CHIPS   = 16;
  localparam int DATA_CHIPS   = 32;
  localparam int PARITY_CHIPS = 2;

  // Bit 1 -> chips 1,0 ; bit 0 -> chips 0,1 (first chip in the MSB)
  function automatic logic [1:0] manchester_enc(input logic b);
    return b ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/bd_tx_chip_shifter.sv
// bd_tx_chip_shifter: sample counter plus left-aligned chip shift register.
// A load starts a segment of i_len chips; each chip is held for
// SAMPLES_PER_CHIP clocks. o_chip is the chip that will be on the line in
// the cycle after the current edge, so the caller can register it straight
// into the DAC without an extra cycle of latency.
module bd_tx_chip_shifter
  import bd_tx_pkg::*;
#(
  parameter int SAMPLES_PER_CHIP = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [DATA_CHIPS-1:0] i_chips,
  input  logic [5:0]            i_len,
  output logic                  o_chip,
  output logic                  o_done
);

  localparam int CW = (SAMPLES_PER_CHIP > 1) ? $clog2(SAMPLES_PER_CHIP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLES_PER_CHIP - 1);

  logic [CW-1:0]         r_cnt;
  logic [DATA_CHIPS-1:0] r_shreg;
  logic [5:0]            r_left;
  logic                  r_active;
  logic                  w_advance;

  assign w_advance = r_active && (r_cnt == CNT_LAST);
  // Last sample of the last chip of the segment
  assign o_done    = w_advance && (r_left == 6'd1);
  assign o_chip    = i_load    ? i_chips[DATA_CHIPS-1] :
                     w_advance ? r_shreg[DATA_CHIPS-2] : r_shreg[DATA_CHIPS-1];

  // Segment load, per-sample counting and chip shifting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_shreg  <= '0;
      r_left   <= '0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_cnt    <= '0;
      r_shreg  <= i_chips;
      r_left   <= i_len;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (w_advance) begin
        r_cnt   <= '0;
        r_shreg <= {r_shreg[DATA_CHIPS-2:0], 1'b0};
        r_left  <= r_left - 6'd1;
        if (r_left == 6'd1) begin
          r_active <= 1'b0;
        end
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/bd_tx_modulator.sv
// bd_tx_modulator: accepts two payload bytes over valid/ready, sends a raw
// sync word followed by the Manchester-encoded payload as DAC levels, and
// pulses int_tx_host once the frame is out.
// Define BD_TX_PARITY_EN to append a Manchester-encoded even-parity bit.
module bd_tx_modulator
  import bd_tx_pkg::*;
#(
  parameter int          SAMPLES_PER_CHIP = 4,
  parameter logic [15:0] SYNC_WORD        = 16'hFF00,
  parameter logic [7:0]  DAC_HIGH         = 8'hE0,
  parameter logic [7:0]  DAC_LOW          = 8'h20,
  parameter logic [7:0]  DAC_IDLE         = 8'h80
) (
  input  logic       G_CLK_TX,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_in,
  output logic [7:0] DAC,
  output logic       tx_busy,
  output logic       int_tx_host
);

  bd_tx_state_t r_state;
  bd_tx_state_t w_state_next;
  logic [7:0]   r_byte0;
  logic [7:0]   r_byte1;
  logic [7:0]   r_dac;
  logic         w_xfer;
  logic         w_load;
  logic         w_chip;
  logic         w_seg_done;
  logic [31:0]  w_load_vec;
  logic [5:0]   w_load_len;
  logic [31:0]  w_sync_vec;
  logic [31:0]  w_data_vec;
  logic [15:0]  w_payload;

  assign w_xfer     = valid_in & ready_in;
  assign w_payload  = {r_byte0, r_byte1};
  assign w_sync_vec = {SYNC_WORD, 16'h0000};
  assign DAC        = r_dac;

  // Manchester-encode BYTE_0 then BYTE_1, MSB first, into 32 chips
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_manch
      assign w_data_vec[31-2*gi -: 2] = manchester_enc(w_payload[15-gi]);
    end
  endgenerate

`ifdef BD_TX_PARITY_EN
  logic        w_parity;
  logic [31:0] w_par_vec;
  assign w_parity  = ^w_payload;
  assign w_par_vec = {manchester_enc(w_parity), 30'b0};
`endif

  bd_tx_chip_shifter #(
    .SAMPLES_PER_CHIP(SAMPLES_PER_CHIP)
  ) u_shifter (
    .clk    (G_CLK_TX),
    .rst_n  (reset),
    .i_load (w_load),
    .i_chips(w_load_vec),
    .i_len  (w_load_len),
    .o_chip (w_chip),
    .o_done (w_seg_done)
  );

  // State register
  always_ff @(posedge G_CLK_TX or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_xfer) w_state_next = WAIT_B1;
      WAIT_B1: if (w_xfer) w_state_next = SYNC;
      SYNC:    if (w_seg_done) w_state_next = DATA;
`ifdef BD_TX_PARITY_EN
      DATA:    if (w_seg_done) w_state_next = PARITY;
`else
      DATA:    if (w_seg_done) w_state_next = DONE;
`endif
      PARITY:  if (w_seg_done) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs and segment loads; ready_in depends on state only, so the
  // WAIT_B1 load uses valid_in directly
  always_comb begin
    ready_in    = (r_state == IDLE) || (r_state == WAIT_B1);
    tx_busy     = (r_state == SYNC) || (r_state == DATA) ||
                  (r_state == PARITY) || (r_state == DONE);
    int_tx_host = (r_state == DONE);
    w_load      = 1'b0;
    w_load_vec  = w_sync_vec;
    w_load_len  = 6'(SYNC_CHIPS);
    case (r_state)
      WAIT_B1: w_load = valid_in;
      SYNC: begin
        if (w_seg_done) begin
          w_load     = 1'b1;
          w_load_vec = w_data_vec;
          w_load_len = 6'(DATA_CHIPS);
        end
      end
`ifdef BD_TX_PARITY_EN
      DATA: begin
        if (w_seg_done) begin
          w_load     = 1'b1;
          w_load_vec = w_par_vec;
          w_load_len = 6'(PARITY_CHIPS);
        end
      end
`endif
      default: ;
    endcase
  end

  // Payload byte latches
  always_ff @(posedge G_CLK_TX or negedge reset) begin
    if (!reset) begin
      r_byte0 <= 8'h00;
      r_byte1 <= 8'h00;
    end else if (w_xfer) begin
      if (r_state == IDLE) begin
        r_byte0 <= data_in;
      end else begin
        r_byte1 <= data_in;
      end
    end
  end

  // Registered DAC level for the chip that is on the line next cycle
  always_ff @(posedge G_CLK_TX or negedge reset) begin
    if (!reset) begin
      r_dac <= DAC_IDLE;
    end else if ((w_state_next == SYNC) || (w_state_next == DATA) ||
                 (w_state_next == PARITY)) begin
      r_dac <= w_chip ? DAC_HIGH : DAC_LOW;
    end else begin
      r_dac <= DAC_IDLE;
    end
  end

endmodule

// File: tb/tb_bd_tx_modulator.sv
// Directed bench for bd_tx_modulator: nominal frames from a vector table,
// inter-byte gap, backpressure, mid-frame reset and a one-sample-per-chip
// instance. Honours BD_TX_PARITY_EN when defined.
module tb_bd_tx_modulator;

  localparam logic [15:0] SYNC_W = 16'hFF00;
`ifdef BD_TX_PARITY_EN
  localparam int NCH = 50;
`else
  localparam int NCH = 48;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       valid0, valid1;
  logic       ready0, busy0, int0, ready1, busy1, int1;
  logic [7:0] dac0, dac1;
  logic       sel;
  logic [7:0] m_dac;
  logic       m_ready, m_busy, m_int;
  int         n_tests, n_fail;

  always #5 clk = ~clk;

  bd_tx_modulator #(.SAMPLES_PER_CHIP(4)) u_dut (
    .G_CLK_TX(clk), .reset(rst_n), .data_in(data_in), .valid_in(valid0),
    .ready_in(ready0), .DAC(dac0), .tx_busy(busy0), .int_tx_host(int0)
  );

  bd_tx_modulator #(.SAMPLES_PER_CHIP(1)) u_dut1 (
    .G_CLK_TX(clk), .reset(rst_n), .data_in(data_in), .valid_in(valid1),
    .ready_in(ready1), .DAC(dac1), .tx_busy(busy1), .int_tx_host(int1)
  );

  always_comb begin
    m_dac   = sel ? dac1   : dac0;
    m_ready = sel ? ready1 : ready0;
    m_busy  = sel ? busy1  : busy0;
    m_int   = sel ? int1   : int0;
  end

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [31:0] vec;
    logic        par;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    chk("ready before byte", {31'b0, m_ready}, 32'd1);
    data_in = b;
    if (sel) valid1 = 1'b1; else valid0 = 1'b1;
    step();
    valid0 = 1'b0;
    valid1 = 1'b0;
  endtask

  // Starts in the cycle after the BYTE_1 transfer edge
  task automatic check_frame(input string name, input logic [31:0] vec,
                             input logic par, input int spc);
    logic [NCH-1:0] chips;
`ifdef BD_TX_PARITY_EN
    chips = {SYNC_W, vec, (par ? 2'b10 : 2'b01)};
`else
    chips = {SYNC_W, vec};
`endif
    for (int c = 0; c < NCH; c++) begin
      for (int s = 0; s < spc; s++) begin
        chk($sformatf("%s chip%0d s%0d {dac,busy,rdy,int}", name, c, s),
            {21'b0, m_dac, m_busy, m_ready, m_int},
            {21'b0, (chips[NCH-1-c] ? 8'hE0 : 8'h20), 3'b100});
        step();
      end
    end
    chk($sformatf("%s done {dac,busy,rdy,int}", name),
        {21'b0, m_dac, m_busy, m_ready, m_int}, {21'b0, 8'h80, 3'b101});
    step();
    chk($sformatf("%s idle {dac,busy,rdy,int}", name),
        {21'b0, m_dac, m_busy, m_ready, m_int}, {21'b0, 8'h80, 3'b010});
    $display("[TB] frame %s vec=%h parity=%0d spc=%0d checked", name, vec, par, spc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    sel     = 1'b0;
    rst_n   = 1'b0;
    data_in = 8'h00;
    valid0  = 1'b0;
    valid1  = 1'b0;

    tbl[0] = '{b0: 8'hA5, b1: 8'h3C, vec: 32'h9966_5AA5, par: 1'b0};
    tbl[1] = '{b0: 8'hFF, b1: 8'h00, vec: 32'hAAAA_5555, par: 1'b0};
    tbl[2] = '{b0: 8'h01, b1: 8'h00, vec: 32'h5556_5555, par: 1'b1};
    tbl[3] = '{b0: 8'h00, b1: 8'hFF, vec: 32'h5555_AAAA, par: 1'b0};
    tbl[4] = '{b0: 8'h80, b1: 8'h01, vec: 32'h9555_5556, par: 1'b0};

    // Reset values (ready_in reads 1 while in reset)
    repeat (3) @(posedge clk);
    #1;
    chk("reset dut4 {dac,busy,rdy,int}", {21'b0, dac0, busy0, ready0, int0}, {21'b0, 8'h80, 3'b010});
    chk("reset dut1 {dac,busy,rdy,int}", {21'b0, dac1, busy1, ready1, int1}, {21'b0, 8'h80, 3'b010});
    rst_n = 1'b1;
    step();

    // Back-to-back frames from the table
    for (int i = 0; i < 5; i++) begin
      send_byte(tbl[i].b0);
      send_byte(tbl[i].b1);
      check_frame($sformatf("tbl%0d", i), tbl[i].vec, tbl[i].par, 4);
    end

    // 50-cycle gap between bytes: stays idle and ready
    send_byte(8'h00);
    for (int g = 0; g < 50; g++) begin
      chk($sformatf("gap%0d {dac,rdy,busy}", g), {22'b0, m_dac, m_ready, m_busy}, {22'b0, 8'h80, 2'b10});
      step();
    end
    send_byte(8'hFF);
    check_frame("gap", 32'h5555_AAAA, 1'b0, 4);

    // Backpressure: 0x11 held valid throughout a frame
    send_byte(8'hA5);
    send_byte(8'h3C);
    data_in = 8'h11;
    valid0  = 1'b1;
    check_frame("bp_busy", 32'h9966_5AA5, 1'b0, 4);
    step();
    valid0 = 1'b0;
    chk("bp accepted once {dac,rdy,busy}", {22'b0, m_dac, m_ready, m_busy}, {22'b0, 8'h80, 2'b10});
    send_byte(8'h22);
    check_frame("bp_next", 32'h5656_5959, 1'b0, 4);

    // Reset at chip 20 (inside DATA)
    send_byte(8'h5A);
    send_byte(8'h0F);
    repeat (20 * 4) step();
    chk("pre-reset busy", {31'b0, m_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset {dac,busy,rdy,int}", {21'b0, m_dac, m_busy, m_ready, m_int}, {21'b0, 8'h80, 3'b010});
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("in reset %0d {dac,busy,rdy,int}", k), {21'b0, m_dac, m_busy, m_ready, m_int}, {21'b0, 8'h80, 3'b010});
    end
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("after reset %0d {dac,busy,rdy,int}", k), {21'b0, m_dac, m_busy, m_ready, m_int}, {21'b0, 8'h80, 3'b010});
    end
    send_byte(8'hA5);
    send_byte(8'h3C);
    check_frame("post_reset", 32'h9966_5AA5, 1'b0, 4);

    // One sample per chip
    sel = 1'b1;
    #1;
    send_byte(8'hFF);
    send_byte(8'h00);
    check_frame("spc1", 32'hAAAA_5555, 1'b0, 1);
    sel = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
